// File: rtl/smi_header_extract_pf1.sv
//==============================================================================
// Module   : smi_header_extract_pf1
// Brief    : Strips a HeadWidth-byte header (HeadWidth < FlitWidth) from each
//            SMI frame and re-aligns the remaining body into a new frame.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module smiSelfLinkBufferFifoS #(
  parameter int Width     = 136,
  parameter int Size      = 16,
  parameter int IndexSize = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inReady,
  input  logic [Width-1:0] inData,
  output logic             inStop,
  output logic             outReady,
  output logic [Width-1:0] outData,
  input  logic             outStop
);
  // Storage holds Size-1 entries so every index fits in IndexSize bits.
  localparam logic [IndexSize-1:0] c_lastIdx = IndexSize'(Size - 2);
  localparam logic [IndexSize:0]   c_depth   = (IndexSize + 1)'(Size - 1);

  logic [Width-1:0]     r_mem [0:Size-2];
  logic [IndexSize-1:0] r_wrPtr;
  logic [IndexSize-1:0] r_rdPtr;
  logic [IndexSize:0]   r_count;
  logic                 w_wr;
  logic                 w_rd;

  assign inStop   = (r_count == c_depth);
  assign outReady = (r_count != '0);
  assign outData  = r_mem[r_rdPtr];
  assign w_wr     = inReady & ~inStop;
  assign w_rd     = outReady & ~outStop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wrPtr] <= inData;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wrPtr <= (r_wrPtr == c_lastIdx) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_rd) begin
        r_rdPtr <= (r_rdPtr == c_lastIdx) ? '0 : r_rdPtr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module smi_header_extract_pf1 #(
  parameter int FlitWidth     = 16,
  parameter int HeadWidth     = 4,
  parameter int FifoSize      = 16,
  parameter int FifoIndexSize = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth*8-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   headerReady,
  output logic [HeadWidth*8-1:0] headerData,
  output logic                   headerEmpty,
  input  logic                   headerStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop
);
  localparam int         FlitSplit    = FlitWidth - HeadWidth;
  localparam logic [7:0] EofcMask     = 8'(2 * FlitWidth - 1);
  localparam logic [7:0] c_headWidth8 = 8'(HeadWidth);
  localparam logic [7:0] c_flitSplit8 = 8'(FlitSplit);

  localparam logic [1:0] c_stIdle = 2'd0;
  localparam logic [1:0] c_stCopy = 2'd1;
  localparam logic [1:0] c_stTail = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_nextState;

  logic                   r_inValid;
  logic [7:0]             r_inEofc;
  logic [FlitWidth*8-1:0] r_inData;
  logic                   w_inLoad;
  logic                   w_inConsume;

  logic                   r_hdrValid;
  logic [HeadWidth*8-1:0] r_hdrData;
  logic                   r_hdrEmpty;
  logic                   w_hdrFree;
  logic                   w_hdrLoad;

  logic [FlitSplit*8-1:0] r_carry;
  logic [7:0]             r_lastEofc;

  logic                   w_inIsShort;
  logic                   w_inIsLong;

  logic                   w_fifoWrValid;
  logic [7:0]             w_fifoWrEofc;
  logic [FlitWidth*8-1:0] w_fifoWrData;
  logic                   w_fifoWrStop;

  // Input holding register
  assign w_inLoad  = ~r_inValid | w_inConsume;
  assign smiInStop = r_inValid & ~w_inConsume;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_inValid <= 1'b0;
    end else if (w_inLoad) begin
      r_inValid <= smiInReady;
    end
  end

  always_ff @(posedge clk) begin
    if (w_inLoad && smiInReady) begin
      r_inEofc <= smiInEofc & EofcMask;
      r_inData <= smiInData;
    end
  end

  // Last flit classification: short ends within the header-sized slice.
  assign w_inIsShort = (r_inEofc != 8'd0) && (r_inEofc <= c_headWidth8);
  assign w_inIsLong  = (r_inEofc > c_headWidth8);

  assign w_hdrFree = ~r_hdrValid | ~headerStop;

  always_comb begin
    w_nextState   = r_state;
    w_inConsume   = 1'b0;
    w_hdrLoad     = 1'b0;
    w_fifoWrValid = 1'b0;
    w_fifoWrEofc  = 8'd0;
    w_fifoWrData  = '0;
    case (r_state)
      c_stIdle: begin
        if (r_inValid && w_hdrFree) begin
          w_inConsume = 1'b1;
          w_hdrLoad   = 1'b1;
          if (r_inEofc == 8'd0) begin
            w_nextState = c_stCopy;
          end else if (w_inIsLong) begin
            w_nextState = c_stTail;
          end
        end
      end
      c_stCopy: begin
        w_fifoWrValid = r_inValid;
        w_fifoWrData  = {r_inData[HeadWidth*8-1:0], r_carry};
        w_fifoWrEofc  = w_inIsShort ? (r_inEofc + c_flitSplit8) : 8'd0;
        if (r_inValid && !w_fifoWrStop) begin
          w_inConsume = 1'b1;
          if (w_inIsShort) begin
            w_nextState = c_stIdle;
          end else if (w_inIsLong) begin
            w_nextState = c_stTail;
          end
        end
      end
      c_stTail: begin
        w_fifoWrValid = 1'b1;
        w_fifoWrData  = {{(HeadWidth*8){1'b0}}, r_carry};
        w_fifoWrEofc  = r_lastEofc - c_headWidth8;
        if (!w_fifoWrStop) begin
          w_nextState = c_stIdle;
        end
      end
      default: begin
        w_nextState = c_stIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= c_stIdle;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (w_inConsume) begin
      r_carry <= r_inData[FlitWidth*8-1:HeadWidth*8];
      if (w_inIsLong) begin
        r_lastEofc <= r_inEofc;
      end
    end
  end

  // Header output stage
  always_ff @(posedge clk) begin
    if (srst) begin
      r_hdrValid <= 1'b0;
    end else if (w_hdrLoad) begin
      r_hdrValid <= 1'b1;
    end else if (!headerStop) begin
      r_hdrValid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hdrLoad) begin
      r_hdrData  <= r_inData[HeadWidth*8-1:0];
      r_hdrEmpty <= w_inIsShort;
    end
  end

  assign headerReady = r_hdrValid;
  assign headerData  = r_hdrData;
  assign headerEmpty = r_hdrEmpty;

  smiSelfLinkBufferFifoS #(
    .Width     ((FlitWidth + 1) * 8),
    .Size      (FifoSize),
    .IndexSize (FifoIndexSize)
  ) bodyFifo (
    .clk      (clk),
    .srst     (srst),
    .inReady  (w_fifoWrValid),
    .inData   ({w_fifoWrEofc, w_fifoWrData}),
    .inStop   (w_fifoWrStop),
    .outReady (smiOutReady),
    .outData  ({smiOutEofc, smiOutData}),
    .outStop  (smiOutStop)
  );
endmodule

`default_nettype wire

// File: tb/tb_smi_header_extract_pf1.sv
//==============================================================================
// Module   : tb_smi_header_extract_pf1
// Brief    : Randomized frame-level bench for smi_header_extract_pf1.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_smi_header_extract_pf1;
  localparam int FW = 16;
  localparam int HW = 4;

  logic            clk = 1'b0;
  logic            srst = 1'b1;
  logic            smiInReady = 1'b0;
  logic [7:0]      smiInEofc = 8'd0;
  logic [FW*8-1:0] smiInData = '0;
  logic            smiInStop;
  logic            headerReady;
  logic [HW*8-1:0] headerData;
  logic            headerEmpty;
  logic            headerStop = 1'b0;
  logic            smiOutReady;
  logic [7:0]      smiOutEofc;
  logic [FW*8-1:0] smiOutData;
  logic            smiOutStop = 1'b0;

  smi_header_extract_pf1 #(.FlitWidth(FW), .HeadWidth(HW), .FifoSize(16), .FifoIndexSize(4)) dut (
    .clk(clk), .srst(srst),
    .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData), .smiInStop(smiInStop),
    .headerReady(headerReady), .headerData(headerData), .headerEmpty(headerEmpty), .headerStop(headerStop),
    .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData), .smiOutStop(smiOutStop)
  );

  always #5 clk = ~clk;

  typedef struct { logic [HW*8-1:0] data; logic empty; } hdrT;
  typedef struct { logic [FW*8-1:0] data; logic [FW*8-1:0] mask; logic [7:0] eofc; } bodyT;

  hdrT  expHdr[$];
  bodyT expBody[$];
  int   testCount = 0;
  int   failCount = 0;
  bit   monEn = 1'b0;
  bit   rndMode = 1'b0;

  task automatic checkValue(input string tag, input logic [FW*8-1:0] obs, input logic [FW*8-1:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output stops toggle randomly in random mode, otherwise held low.
  always @(posedge clk) begin
    #1;
    headerStop = rndMode ? 1'($urandom_range(0, 1)) : 1'b0;
    smiOutStop = rndMode ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Transfers complete at the next posedge; everything is stable at negedge.
  always @(negedge clk) begin
    if (monEn && !srst) begin
      if (headerReady && !headerStop) begin
        checkValue("hdrExtra", 128'(expHdr.size() != 0), 128'(1));
        if (expHdr.size() != 0) begin
          hdrT h;
          h = expHdr.pop_front();
          checkValue("hdrData", 128'(headerData), 128'(h.data));
          checkValue("hdrEmpty", 128'(headerEmpty), 128'(h.empty));
        end
      end
      if (smiOutReady && !smiOutStop) begin
        checkValue("bodyExtra", 128'(expBody.size() != 0), 128'(1));
        if (expBody.size() != 0) begin
          bodyT b;
          b = expBody.pop_front();
          checkValue("bodyEofc", 128'(smiOutEofc), 128'(b.eofc));
          checkValue("bodyData", smiOutData & b.mask, b.data);
        end
      end
    end
  end

  task automatic sendFlit(input logic [FW*8-1:0] d, input logic [7:0] e, output int stalls);
    bit stopSeen;
    stalls = 0;
    while (rndMode && $urandom_range(0, 1) == 0) begin
      smiInReady = 1'b0;
      @(posedge clk); #1;
    end
    smiInReady = 1'b1;
    smiInData  = d;
    smiInEofc  = e;
    do begin
      @(negedge clk);
      stopSeen = smiInStop;
      @(posedge clk); #1;
      if (stopSeen) stalls++;
    end while (stopSeen && stalls < 2000);
    if (stalls >= 2000) checkValue("inTimeout", 128'(stalls), 128'(0));
    smiInReady = 1'b0;
  endtask

  // Builds a frame, records expected header/body and drives it.
  // stopAfter > 0 abandons the frame after that many flits without recording.
  task automatic sendFrame(input int len, input bit seq, input int stopAfter, output int stalls);
    byte unsigned fb[];
    int nfl, bodyLen, nb, st;
    logic [FW*8-1:0] d;
    logic [7:0] e;
    fb = new[len];
    for (int i = 0; i < len; i++) fb[i] = seq ? 8'(i) : 8'($urandom);
    nfl = (len + FW - 1) / FW;
    stalls = 0;
    for (int f = 0; f < nfl; f++) begin
      for (int i = 0; i < FW; i++)
        d[i*8 +: 8] = (f*FW + i < len) ? fb[f*FW + i] : 8'($urandom);
      e = (f == nfl - 1) ? 8'(len - FW*(nfl - 1)) : 8'd0;
      if (f == 0 && stopAfter == 0) begin
        hdrT h;
        h.data  = d[HW*8-1:0];
        h.empty = (len <= HW);
        expHdr.push_back(h);
        bodyLen = len - HW;
        nb = (bodyLen + FW - 1) / FW;
        for (int c = 0; c < nb; c++) begin
          bodyT b;
          b.data = '0; b.mask = '0;
          for (int i = 0; i < FW; i++) begin
            if (c*FW + i < bodyLen) begin
              b.data[i*8 +: 8] = fb[HW + c*FW + i];
              b.mask[i*8 +: 8] = 8'hFF;
            end
          end
          b.eofc = (c == nb - 1) ? 8'(bodyLen - FW*(nb - 1)) : 8'd0;
          expBody.push_back(b);
        end
      end
      if (stopAfter != 0 && f == stopAfter) return;
      sendFlit(d, e, st);
      if (f > 0) stalls += st;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expHdr.size() != 0 || expBody.size() != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checkValue("drainTimeout", 128'(n < 5000), 128'(1));
  endtask

  initial begin
    int st;
    srst = 1'b1;
    @(posedge clk); #1;
    checkValue("rstHdrReady", 128'(headerReady), 128'(0));
    checkValue("rstOutReady", 128'(smiOutReady), 128'(0));
    checkValue("rstInStop", 128'(smiInStop), 128'(0));
    @(posedge clk); #1;
    srst = 1'b0;
    monEn = 1'b1;

    // Directed frames from the plan: 10, 4, 19 and 32 bytes of 0x00.. data
    sendFrame(10, 1'b1, 0, st);
    sendFrame(4, 1'b1, 0, st);
    sendFrame(19, 1'b1, 0, st);
    sendFrame(32, 1'b1, 0, st);
    sendFrame(1, 1'b1, 0, st);
    sendFrame(20, 1'b1, 0, st);
    drain();

    // Long frame with no stops must stream without input stalls.
    sendFrame(160, 1'b0, 0, st);
    checkValue("thruStall", 128'(st), 128'(0));
    drain();

    // Reset while in the Copy state, then a clean frame.
    monEn = 1'b0;
    sendFrame(80, 1'b0, 3, st);
    srst = 1'b1;
    @(posedge clk); #1;
    checkValue("midRstHdrReady", 128'(headerReady), 128'(0));
    checkValue("midRstOutReady", 128'(smiOutReady), 128'(0));
    checkValue("midRstInStop", 128'(smiInStop), 128'(0));
    srst = 1'b0;
    expHdr.delete();
    expBody.delete();
    monEn = 1'b1;
    sendFrame(45, 1'b0, 0, st);
    drain();

    // Random traffic with random stops and input gaps.
    rndMode = 1'b1;
    for (int k = 0; k < 1000; k++) sendFrame($urandom_range(1, 200), 1'b0, 0, st);
    drain();
    rndMode = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkValue("endHdrIdle", 128'(headerReady), 128'(0));
    checkValue("endOutIdle", 128'(smiOutReady), 128'(0));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

`default_nettype wire
